// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - pixel and 5x5 window geometry shared with the edge filter
package image_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_N    = 5;
    localparam int WIN_BITS = WIN_N * WIN_N * PIX_W;

    // LSB of element (row r, col c) inside the packed window
    function automatic int win_lsb(input int r, input int c);
        return PIX_W * (WIN_N * r + c);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port line store, async read at the write address
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Old contents are visible in the write cycle, giving read-before-write
    assign rdata = mem[addr];

endmodule

// File: rtl/sliding_window_5x5.sv
// rtl/sliding_window_5x5.sv - raster stream to packed 5x5 windows; SLIDING_WINDOW_COORD_EN adds win_x/win_y
module sliding_window_5x5
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    pix_in,
    input  logic                in_valid,
    input  logic                sof,
    output logic                in_ready,
    output logic [WIN_BITS-1:0] window_out,
    output logic                win_valid,
    input  logic                win_ready
`ifdef SLIDING_WINDOW_COORD_EN
    ,
    output logic [15:0]         win_x,
    output logic [15:0]         win_y
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0]    x, cur_x;
    logic [YW-1:0]    y, cur_y;
    logic             accept;
    logic             emit;
    logic [PIX_W-1:0] lb_rd [4];
    logic [PIX_W-1:0] lb_wr [4];
    logic [PIX_W-1:0] win [WIN_N][WIN_N];

    assign in_ready = !rst && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;

    // sof forces the accepted pixel to (0,0) regardless of the counters
    assign cur_x = sof ? '0 : x;
    assign cur_y = sof ? '0 : y;
    assign emit  = (cur_x >= XW'(WIN_N - 1)) && (cur_y >= YW'(WIN_N - 1));

    assign lb_wr[3] = pix_in;
    assign lb_wr[2] = lb_rd[3];
    assign lb_wr[1] = lb_rd[2];
    assign lb_wr[0] = lb_rd[1];

    for (genvar i = 0; i < 4; i++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (PIX_W)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_x),
            .wdata (lb_wr[i]),
            .rdata (lb_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (cur_x == XW'(IMG_WIDTH - 1)) begin
                x <= '0;
                y <= (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x <= cur_x + XW'(1);
                y <= cur_y;
            end
        end
    end

    // The shift register doubles as the output register: it only moves on accept,
    // and accept is blocked while a window is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            for (int r = 0; r < 4; r++) begin
                win[r][WIN_N-1] <= lb_rd[r];
            end
            win[WIN_N-1][WIN_N-1] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
        end else if (accept) begin
            win_valid <= emit;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    always_comb begin
        window_out = '0;
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N; c++) begin
                window_out[win_lsb(r, c) +: PIX_W] = win[r][c];
            end
        end
    end

`ifdef SLIDING_WINDOW_COORD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (accept && emit) begin
            win_x <= 16'(cur_x) - 16'd2;
            win_y <= 16'(cur_y) - 16'd2;
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_5x5.sv
// tb/tb_sliding_window_5x5.sv - randomized bench with image-array reference model
module tb_sliding_window_5x5;

    localparam int W = 8;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   pix_in = '0;
    logic         in_valid = 1'b0;
    logic         sof = 1'b0;
    logic         in_ready;
    logic [199:0] window_out;
    logic         win_valid;
    logic         win_ready = 1'b1;
`ifdef SLIDING_WINDOW_COORD_EN
    logic [15:0]  win_x, win_y;
`endif

    always #5 clk = ~clk;

    sliding_window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .in_valid   (in_valid),
        .sof        (sof),
        .in_ready   (in_ready),
        .window_out (window_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready)
`ifdef SLIDING_WINDOW_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [7:0]   img [H][W];
    logic [199:0] q_win [$];
    int           q_x [$];
    int           q_y [$];
    int           mx = 0, my = 0;
    int           win_cnt = 0;
    int           phase = 0;
    int           ready_mode = 0;
    int           stall_left = 0;
    bit           stall_done = 0;
    logic         held = 1'b0;
    logic [199:0] held_win = '0;
    logic         rst_edge = 1'b1;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window centred two pixels up/left of (x,y), straight from the stored image
    function automatic logic [199:0] build(input int x, input int y);
        logic [199:0] w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r*40 + c*8 +: 8] = img[y-4+r][x-4+c];
        return w;
    endfunction

    always @(posedge clk) begin
        int px, py;
        rst_edge = rst;
        held     = win_valid && !win_ready && !rst;
        held_win = window_out;
        if (rst) begin
            q_win.delete(); q_x.delete(); q_y.delete();
            mx = 0; my = 0;
        end else begin
            if (win_valid && win_ready && q_win.size() > 0) begin
                void'(q_win.pop_front()); void'(q_x.pop_front()); void'(q_y.pop_front());
                win_cnt++;
            end
            if (in_valid && in_ready) begin
                px = sof ? 0 : mx;
                py = sof ? 0 : my;
                img[py][px] = pix_in;
                if (px >= 4 && py >= 4) begin
                    q_win.push_back(build(px, py));
                    q_x.push_back(px - 2);
                    q_y.push_back(py - 2);
                end
                if (px == W - 1) begin
                    mx = 0;
                    my = (py == H - 1) ? 0 : py + 1;
                end else begin
                    mx = px + 1;
                    my = py;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [199:0] lw;
        lw = window_out;
        chk("in_ready", 200'(in_ready), 200'(!rst && (!win_valid || win_ready)));
        if (rst_edge) begin
            chk("rst_win_valid", 200'(win_valid), 200'(0));
            chk("rst_window_out", window_out, 200'(0));
`ifdef SLIDING_WINDOW_COORD_EN
            chk("rst_win_x", 200'(win_x), 200'(0));
            chk("rst_win_y", 200'(win_y), 200'(0));
`endif
        end else begin
            chk("win_valid", 200'(win_valid), 200'(q_win.size() > 0));
            if (win_valid && q_win.size() > 0) begin
                chk("window", window_out, q_win[0]);
`ifdef SLIDING_WINDOW_COORD_EN
                chk("win_x", 200'(win_x), 200'(q_x[0]));
                chk("win_y", 200'(win_y), 200'(q_y[0]));
`endif
            end
            if (held) begin
                chk("hold_valid", 200'(win_valid), 200'(1));
                chk("hold_window", window_out, held_win);
            end
            if (phase == 1 && win_valid && win_cnt == 0) begin
                chk("first_b0", 200'(lw[7:0]), 200'(8'h00));
                chk("first_b4", 200'(lw[39:32]), 200'(8'h04));
                chk("first_b20", 200'(lw[167:160]), 200'(8'h40));
                chk("first_b24", 200'(lw[199:192]), 200'(8'h44));
`ifdef SLIDING_WINDOW_COORD_EN
                chk("first_x", 200'(win_x), 200'(2));
                chk("first_y", 200'(win_y), 200'(2));
`endif
            end
            if (phase == 1 && win_valid && win_cnt == 7) begin
                chk("last_b24", 200'(lw[199:192]), 200'(8'h57));
                chk("last_b0", 200'(lw[7:0]), 200'(8'h13));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: win_ready = 1'b1;
                1: win_ready = ($urandom_range(3) != 0);
                default: begin
                    if (stall_left > 0) begin
                        win_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_done && win_valid) begin
                        win_ready  = 1'b0;
                        stall_left = 2;
                        stall_done = 1;
                    end else begin
                        win_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        sof      = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] p, input logic s, input bit gaps);
        bit acc = 0;
        if (gaps) idle($urandom_range(2));
        in_valid = 1'b1;
        pix_in   = p;
        sof      = s;
        for (int t = 0; t < 200 && !acc; t++) begin
            #2;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic frame(input int base, input bit s, input bit gaps, input bit rnd);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                send(rnd ? 8'($urandom) : 8'(base + 16*yy + xx), s && xx == 0 && yy == 0, gaps);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        phase = 1; win_cnt = 0;
        frame(0, 1, 0, 0);
        idle(4);
        chk("count_frame1", 200'(win_cnt), 200'(8));
        phase = 0;

        win_cnt = 0;
        frame(8'h80, 0, 0, 0);
        frame(0, 0, 0, 0);
        idle(4);
        chk("count_back2back", 200'(win_cnt), 200'(16));

        ready_mode = 2; stall_done = 0; win_cnt = 0;
        frame(8'h20, 1, 0, 0);
        idle(4);
        chk("count_backpressure", 200'(win_cnt), 200'(8));

        ready_mode = 1; win_cnt = 0;
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < W && !(yy == 2 && xx > 2); xx++)
                send(8'($urandom), xx == 0 && yy == 0, 1);
        frame(0, 1, 1, 1);
        idle(6);
        chk("count_mid_sof", 200'(win_cnt), 200'(8));

        win_cnt = 0;
        repeat (3) frame(0, 0, 1, 1);
        idle(6);
        chk("count_random", 200'(win_cnt), 200'(24));

        ready_mode = 0;
        for (int yy = 0; yy < 5; yy++)
            for (int xx = 0; xx < W && !(yy == 4 && xx > 5); xx++)
                send(8'(16*yy + xx), xx == 0 && yy == 0, 0);
        chk("valid_before_rst", 200'(win_valid), 200'(1));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        win_cnt = 0;
        frame(8'h40, 0, 1, 0);
        idle(4);
        chk("count_after_rst", 200'(win_cnt), 200'(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
